// File: rtl/demod_pkg.sv
// Shared types and constants for the coherent bit-recovery path.
package demod_pkg;

    // Modulation selector encoding, shared with the transmit modulator.
    typedef enum logic [1:0] {
        ASK    = 2'b00,
        FSK    = 2'b01,
        BPSK   = 2'b10,
        OFFSET = 2'b11
    } mod_mode_t;

    // Receiver control states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } demod_state_t;

    localparam int SAMPLE_W    = 12;
    localparam int PROD_W      = 2 * SAMPLE_W;
    // Offset keying sends 0 for a one and -2048 for a zero; the threshold
    // sits halfway, i.e. -1024 per sample.
    localparam int OFFSET_HALF = 1024;

endpackage

// File: rtl/corr_accum.sv
// Per-symbol accumulators: correlation, reference energy and signal level.
// Counts accepted samples and, on the last sample of a symbol, snapshots the
// sums into decision registers and restarts on the same edge.
module corr_accum
    import demod_pkg::*;
#(
    parameter int SPB   = 16,
    parameter int CNT_W = $clog2(SPB),
    parameter int ACC_W = 24 + CNT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,          // discard count and sums
    input  logic                       acc_en,       // accept the current sample
    input  logic signed [SAMPLE_W-1:0] signal_mod,
    input  logic signed [SAMPLE_W-1:0] ref_carrier,
    output logic                       done,         // snapshot registers just updated
    output logic signed [ACC_W-1:0]    corr_snap,
    output logic signed [ACC_W-1:0]    energy_snap,
    output logic signed [ACC_W-1:0]    level_snap
);

    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_base;
    logic signed [ACC_W-1:0] corr_q, corr_d, corr_base, corr_sum;
    logic signed [ACC_W-1:0] energy_q, energy_d, energy_base, energy_sum;
    logic signed [ACC_W-1:0] level_q, level_d, level_base, level_sum;
    logic signed [ACC_W-1:0] corr_snap_q, corr_snap_d;
    logic signed [ACC_W-1:0] energy_snap_q, energy_snap_d;
    logic signed [ACC_W-1:0] level_snap_q, level_snap_d;
    logic                    done_q, done_d;

    logic signed [PROD_W-1:0] sig_ext, ref_ext, prod, sq;

    // Full-precision products, sign-extended to the accumulator width.
    always_comb begin
        sig_ext = {{SAMPLE_W{signal_mod[SAMPLE_W-1]}}, signal_mod};
        ref_ext = {{SAMPLE_W{ref_carrier[SAMPLE_W-1]}}, ref_carrier};
        prod    = sig_ext * ref_ext;
        sq      = ref_ext * ref_ext;
    end

    // A clear restarts from zero; an accepted sample on the same cycle becomes sample 0.
    always_comb begin
        cnt_base      = clr ? '0 : cnt_q;
        corr_base     = clr ? '0 : corr_q;
        energy_base   = clr ? '0 : energy_q;
        level_base    = clr ? '0 : level_q;
        corr_sum      = corr_base   + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        energy_sum    = energy_base + {{(ACC_W-PROD_W){sq[PROD_W-1]}}, sq};
        level_sum     = level_base  + {{(ACC_W-SAMPLE_W){signal_mod[SAMPLE_W-1]}}, signal_mod};
        cnt_d         = cnt_base;
        corr_d        = corr_base;
        energy_d      = energy_base;
        level_d       = level_base;
        corr_snap_d   = corr_snap_q;
        energy_snap_d = energy_snap_q;
        level_snap_d  = level_snap_q;
        done_d        = 1'b0;
        if (acc_en) begin
            if (cnt_base == CNT_W'(SPB - 1)) begin
                corr_snap_d   = corr_sum;
                energy_snap_d = energy_sum;
                level_snap_d  = level_sum;
                done_d        = 1'b1;
                cnt_d         = '0;
                corr_d        = '0;
                energy_d      = '0;
                level_d       = '0;
            end else begin
                cnt_d    = cnt_base + CNT_W'(1);
                corr_d   = corr_sum;
                energy_d = energy_sum;
                level_d  = level_sum;
            end
        end
    end

    // Accumulator, counter and snapshot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            corr_q        <= '0;
            energy_q      <= '0;
            level_q       <= '0;
            corr_snap_q   <= '0;
            energy_snap_q <= '0;
            level_snap_q  <= '0;
            done_q        <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            corr_q        <= corr_d;
            energy_q      <= energy_d;
            level_q       <= level_d;
            corr_snap_q   <= corr_snap_d;
            energy_snap_q <= energy_snap_d;
            level_snap_q  <= level_snap_d;
            done_q        <= done_d;
        end
    end

    assign done        = done_q;
    assign corr_snap   = corr_snap_q;
    assign energy_snap = energy_snap_q;
    assign level_snap  = level_snap_q;

endmodule

// File: rtl/mod_demod.sv
// Coherent bit recovery: correlates received samples against the local
// reference over one symbol and decides the transmitted bit for ASK, BPSK
// and offset keying. Holds the control FSM, mode-change detect and decision.
module mod_demod
    import demod_pkg::*;
#(
    parameter int SPB   = 16,
    parameter int CNT_W = $clog2(SPB),
    parameter int ACC_W = 24 + CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          modulation_selector,
    input  logic                sym_sync,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] signal_mod,
    input  logic [SAMPLE_W-1:0] ref_carrier,
    output logic                bit_out,
    output logic                bit_valid,
    output logic                locked,
    output logic                mode_err
);

    // Offset-mode threshold: halfway between all-zero and all-(-2048) symbols.
    localparam logic signed [ACC_W-1:0] OFF_THR = ACC_W'(-(SPB * OFFSET_HALF));

    demod_state_t state_q, state_d;
    mod_mode_t    sel, mode_q, mode_d;
    logic         mode_err_q, mode_err_d;
    logic         bit_out_q, bit_out_d;
    logic         bit_valid_q, bit_valid_d;

    logic go, abort, acc_clr, acc_en, done, decision;
    logic signed [ACC_W-1:0] corr_snap, energy_snap, level_snap;
    logic signed [ACC_W:0]   corr_x2, energy_ext;

    assign sel = mod_mode_t'(modulation_selector);

    // Start on a symbol boundary in a supported mode; leave on any selector
    // change or unsupported mode. Any sym_sync while accumulating re-aligns.
    always_comb begin
        go      = (state_q == ST_IDLE) && sym_sync && (sel != FSK);
        abort   = (state_q == ST_ACCUM) && ((sel != mode_q) || (sel == FSK));
        acc_clr = go || abort || ((state_q == ST_ACCUM) && sym_sync);
        acc_en  = sample_valid && !abort && ((state_q == ST_ACCUM) || go);
    end

    corr_accum #(
        .SPB   (SPB),
        .CNT_W (CNT_W),
        .ACC_W (ACC_W)
    ) u_corr_accum (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (acc_clr),
        .acc_en      (acc_en),
        .signal_mod  (signal_mod),
        .ref_carrier (ref_carrier),
        .done        (done),
        .corr_snap   (corr_snap),
        .energy_snap (energy_snap),
        .level_snap  (level_snap)
    );

    // Bit decision from the snapshot, using the mode the symbol was received in.
    always_comb begin
        corr_x2    = {corr_snap, 1'b0};
        energy_ext = {energy_snap[ACC_W-1], energy_snap};
        decision   = 1'b0;
        case (mode_q)
            ASK:     decision = (corr_x2 > energy_ext);
            BPSK:    decision = !corr_snap[ACC_W-1] && (corr_snap != '0);
            OFFSET:  decision = (level_snap > OFF_THR);
            default: decision = 1'b0;
        endcase
    end

    // Next state, mode tracking and output register inputs.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (go)    state_d = ST_ACCUM;
            ST_ACCUM: if (abort) state_d = ST_IDLE;
            default:             state_d = ST_IDLE;
        endcase
        mode_d      = sel;
        mode_err_d  = (sel == FSK);
        // A mode change landing on the decision cycle drops the bit.
        bit_valid_d = done && (state_q == ST_ACCUM) && !abort;
        bit_out_d   = bit_valid_d ? decision : bit_out_q;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= ASK;
            mode_err_q  <= 1'b0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            mode_err_q  <= mode_err_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
        end
    end

    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign locked    = (state_q == ST_ACCUM);
    assign mode_err  = mode_err_q;

endmodule

// File: tb/tb_mod_demod.sv
// Bench for mod_demod with SPB=4: table of single-symbol vectors, hand-written
// corner sequences and a long LFSR BPSK run, all checked through a queue of
// expected bits with their due cycle.
module tb_mod_demod;
    import demod_pkg::*;

    localparam int SPB = 4;

    logic        clk;
    logic        rst_n;
    logic [1:0]  modulation_selector;
    logic        sym_sync;
    logic        sample_valid;
    logic [11:0] signal_mod;
    logic [11:0] ref_carrier;
    logic        bit_out;
    logic        bit_valid;
    logic        locked;
    logic        mode_err;

    mod_demod #(.SPB(SPB)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .modulation_selector (modulation_selector),
        .sym_sync            (sym_sync),
        .sample_valid        (sample_valid),
        .signal_mod          (signal_mod),
        .ref_carrier         (ref_carrier),
        .bit_out             (bit_out),
        .bit_valid           (bit_valid),
        .locked              (locked),
        .mode_err            (mode_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        mod_mode_t   mode;
        logic [11:0] sig;
        logic [11:0] refc;
        bit          gap;
        bit          exp;
        string       name;
    } vec_t;

    typedef struct {
        bit b;
        int due;
        int id;
    } exp_t;

    localparam int NV = 14;
    vec_t vecs[NV];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_push = 0;
    logic [15:0] lfsr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("check %s: %0h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Drive one cycle of inputs, then return 1ns after the edge that sampled them.
    task automatic step(input bit v, input bit s, input logic [11:0] sg, input logic [11:0] rf);
        sample_valid = v;
        sym_sync     = s;
        signal_mod   = sg;
        ref_carrier  = rf;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        sym_sync     = 1'b0;
    endtask

    // Called just before driving the last sample of a symbol: the bit is due
    // two edges later (accept edge, then decision edge).
    task automatic push_exp(input bit b);
        exp_t e;
        e.b   = b;
        e.due = cyc + 2;
        e.id  = n_push;
        n_push++;
        exp_q.push_back(e);
    endtask

    task automatic symbol(input logic [11:0] sg, input logic [11:0] rf, input bit gap,
                          input bit sync, input bit b, input bit do_push);
        for (int i = 0; i < SPB; i++) begin
            if (gap && i > 0) step(1'b0, 1'b0, 12'($urandom), 12'($urandom));
            if (do_push && i == SPB - 1) push_exp(b);
            step(1'b1, sync && (i == 0), sg, rf);
        end
    endtask

    // Let any pending decision issue under the old mode, then switch.
    task automatic set_mode(input mod_mode_t m);
        if (modulation_selector != m) begin
            step(1'b0, 1'b0, 12'h000, 12'h000);
            modulation_selector = m;
            step(1'b0, 1'b0, 12'h000, 12'h000);
            step(1'b0, 1'b0, 12'h000, 12'h000);
        end
    endtask

    // Compare every strobe against the queue head, flag missing strobes.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_bit %0d: bit_valid=0, required a strobe at cycle %0d", e.id, e.due);
            end
            if (bit_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_bit: bit_valid=1 bit_out=%0b at cycle %0d, required no strobe",
                             bit_out, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (bit_out !== e.b || cyc != e.due) begin
                        errors++;
                        $display("FAIL bit %0d: got bit_out=%0b at cycle %0d, required %0b at cycle %0d",
                                 e.id, bit_out, cyc, e.b, e.due);
                    end else begin
                        $display("bit %0d: bit_out=%0b at cycle %0d", e.id, bit_out, cyc);
                    end
                end
            end
        end
    endtask

    initial begin
        logic [11:0] a;
        logic [11:0] r;
        bit          b;

        vecs[0]  = '{BPSK,   12'h7FF, 12'h7FF, 1'b0, 1'b1, "bpsk_pos"};
        vecs[1]  = '{BPSK,   12'h801, 12'h7FF, 1'b0, 1'b0, "bpsk_neg"};
        vecs[2]  = '{BPSK,   12'h000, 12'h7FF, 1'b0, 1'b0, "bpsk_zero_corr"};
        vecs[3]  = '{BPSK,   12'h7FF, 12'h7FF, 1'b1, 1'b1, "bpsk_gap"};
        vecs[4]  = '{ASK,    12'h400, 12'h400, 1'b0, 1'b1, "ask_on"};
        vecs[5]  = '{ASK,    12'h000, 12'h400, 1'b0, 1'b0, "ask_off"};
        vecs[6]  = '{ASK,    12'h200, 12'h400, 1'b0, 1'b0, "ask_tie"};
        vecs[7]  = '{ASK,    12'h201, 12'h400, 1'b0, 1'b1, "ask_above_tie"};
        vecs[8]  = '{OFFSET, 12'h800, 12'h7FF, 1'b0, 1'b0, "off_zero"};
        vecs[9]  = '{OFFSET, 12'h000, 12'h7FF, 1'b0, 1'b1, "off_one"};
        vecs[10] = '{OFFSET, 12'h800, 12'h7FF, 1'b1, 1'b0, "off_zero_gap"};
        vecs[11] = '{OFFSET, 12'h000, 12'h7FF, 1'b1, 1'b1, "off_one_gap"};
        vecs[12] = '{OFFSET, 12'hC00, 12'h7FF, 1'b0, 1'b0, "off_at_threshold"};
        vecs[13] = '{OFFSET, 12'hC01, 12'h7FF, 1'b0, 1'b1, "off_above_threshold"};

        rst_n               = 1'b0;
        modulation_selector = BPSK;
        sym_sync            = 1'b0;
        sample_valid        = 1'b0;
        signal_mod          = 12'h000;
        ref_carrier         = 12'h000;
        fork
            monitor();
        join_none

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_bit_out", 32'(bit_out), 32'd0);
        chk("reset_bit_valid", 32'(bit_valid), 32'd0);
        chk("reset_locked", 32'(locked), 32'd0);
        chk("reset_mode_err", 32'(mode_err), 32'd0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 12'h000, 12'h000);
        chk("idle_locked", 32'(locked), 32'd0);

        // Table of single symbols, each opened with sym_sync.
        for (int i = 0; i < NV; i++) begin
            set_mode(vecs[i].mode);
            $display("vector %0d %s", i, vecs[i].name);
            symbol(vecs[i].sig, vecs[i].refc, vecs[i].gap, 1'b1, vecs[i].exp, 1'b1);
        end
        chk("locked_after_table", 32'(locked), 32'd1);

        // sym_sync on what would be the last sample: partial symbol discarded.
        set_mode(BPSK);
        for (int i = 0; i < SPB - 1; i++) step(1'b1, i == 0, 12'h7FF, 12'h7FF);
        symbol(12'h801, 12'h7FF, 1'b0, 1'b1, 1'b0, 1'b1);
        // sym_sync after two samples: next bit needs four further samples.
        step(1'b1, 1'b1, 12'h801, 12'h7FF);
        step(1'b1, 1'b0, 12'h801, 12'h7FF);
        symbol(12'h7FF, 12'h7FF, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 12'h000, 12'h000);
        chk("bit_out_held", 32'(bit_out), 32'd1);

        // Reset mid-symbol clears everything at once and stays idle after.
        step(1'b1, 1'b1, 12'h7FF, 12'h7FF);
        step(1'b1, 1'b0, 12'h7FF, 12'h7FF);
        rst_n = 1'b0;
        #1;
        chk("midrst_bit_out", 32'(bit_out), 32'd0);
        chk("midrst_locked", 32'(locked), 32'd0);
        chk("midrst_bit_valid", 32'(bit_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 12'h7FF, 12'h7FF);
        chk("post_rst_idle", 32'(locked), 32'd0);

        // Unsupported mode mid-symbol.
        step(1'b1, 1'b1, 12'h7FF, 12'h7FF);
        step(1'b1, 1'b0, 12'h7FF, 12'h7FF);
        chk("accum_locked", 32'(locked), 32'd1);
        modulation_selector = FSK;
        step(1'b1, 1'b0, 12'h7FF, 12'h7FF);
        chk("fsk_mode_err", 32'(mode_err), 32'd1);
        chk("fsk_locked", 32'(locked), 32'd0);
        symbol(12'h7FF, 12'h7FF, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("fsk_stays_idle", 32'(locked), 32'd0);
        modulation_selector = BPSK;
        step(1'b0, 1'b0, 12'h000, 12'h000);
        step(1'b0, 1'b0, 12'h000, 12'h000);
        chk("mode_err_clear", 32'(mode_err), 32'd0);
        symbol(12'h801, 12'h7FF, 1'b0, 1'b1, 1'b0, 1'b1);
        symbol(12'h7FF, 12'h7FF, 1'b0, 1'b1, 1'b1, 1'b1);

        // Mode change on the last sample: no decision.
        for (int i = 0; i < SPB - 1; i++) step(1'b1, i == 0, 12'h801, 12'h7FF);
        modulation_selector = ASK;
        step(1'b1, 1'b0, 12'h801, 12'h7FF);
        chk("change_last_unlocked", 32'(locked), 32'd0);
        // Mode change on the decision cycle: pending bit dropped.
        set_mode(BPSK);
        symbol(12'h801, 12'h7FF, 1'b0, 1'b1, 1'b0, 1'b0);
        modulation_selector = OFFSET;
        step(1'b0, 1'b0, 12'h000, 12'h000);
        chk("change_decision_unlocked", 32'(locked), 32'd0);
        chk("dropped_bit_out_held", 32'(bit_out), 32'd1);

        // Continuous BPSK, one sym_sync, LFSR data, random amplitudes.
        set_mode(BPSK);
        lfsr = 16'hACE1;
        for (int k = 0; k < 256; k++) begin
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            b    = lfsr[0];
            for (int i = 0; i < SPB; i++) begin
                a = 12'($urandom_range(1, 2047));
                r = 12'($urandom_range(1, 2047));
                if (i == SPB - 1) push_exp(b);
                step(1'b1, (k == 0) && (i == 0), b ? a : 12'(-a), r);
            end
        end

        repeat (4) step(1'b0, 1'b0, 12'h000, 12'h000);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
